// File: rtl/microcode_sequencer.sv
// Writable ARC-style microcode sequencer: control store RAM, CSAR, registered MIR,
// next-address selection (increment / conditional / jump / DECODE) and memory-wait stalls.
module microcode_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS      = 11,
  parameter int DATAWIDTH_MICROINSTRUCTION = 41,
  parameter int DATAWIDTH_CONDITION        = 3,
  parameter int COND_LSB                   = 11,
  parameter int WR_BIT                     = 18,
  parameter int RD_BIT                     = 19,
  parameter int DATAWIDTH_IR               = 32
) (
  input  logic                                  MICROCODE_SEQUENCER_CLOCK_50,
  input  logic                                  MICROCODE_SEQUENCER_ResetInLow_In,
  input  logic [3:0]                            MICROCODE_SEQUENCER_Flags_InBus,
  input  logic [DATAWIDTH_IR-1:0]               MICROCODE_SEQUENCER_IR_InBus,
  input  logic                                  MICROCODE_SEQUENCER_MemReady_In,
  input  logic                                  MICROCODE_SEQUENCER_Load_In,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0]      MICROCODE_SEQUENCER_LoadAddress_InBus,
  input  logic [DATAWIDTH_MICROINSTRUCTION-1:0] MICROCODE_SEQUENCER_LoadData_InBus,
  input  logic                                  MICROCODE_SEQUENCER_LoadWrite_In,
  output logic [DATAWIDTH_MICROINSTRUCTION-1:0] MICROCODE_SEQUENCER_MIR_OutBus,
  output logic [DATAWIDTH_JUMPADDRESS-1:0]      MICROCODE_SEQUENCER_CSAddress_OutBus,
  output logic                                  MICROCODE_SEQUENCER_RD_Out,
  output logic                                  MICROCODE_SEQUENCER_WRMain_Out,
  output logic                                  MICROCODE_SEQUENCER_Stall_Out,
  output logic                                  MICROCODE_SEQUENCER_Loading_Out
);

  localparam int CS_DEPTH = 1 << DATAWIDTH_JUMPADDRESS;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  logic                                  clk;
  logic                                  rst_n;
  logic [3:0]                            flags;
  logic [DATAWIDTH_IR-1:0]               ir;
  logic                                  mem_ready;

  assign clk       = MICROCODE_SEQUENCER_CLOCK_50;
  assign rst_n     = MICROCODE_SEQUENCER_ResetInLow_In;
  assign flags     = MICROCODE_SEQUENCER_Flags_InBus;
  assign ir        = MICROCODE_SEQUENCER_IR_InBus;
  assign mem_ready = MICROCODE_SEQUENCER_MemReady_In;

  logic [DATAWIDTH_MICROINSTRUCTION-1:0] cs_mem [0:CS_DEPTH-1];

  state_t                                state_q, state_d;
  logic [DATAWIDTH_JUMPADDRESS-1:0]      csar_q, csar_d;
  logic [DATAWIDTH_MICROINSTRUCTION-1:0] mir_q;
  logic                                  stall_q, stall_d;
  logic                                  loading_q, loading_d;
  logic                                  active_q, active_d;

  logic                                  mir_en;
  logic [DATAWIDTH_JUMPADDRESS-1:0]      mir_addr;
  logic                                  cs_we;

  logic [DATAWIDTH_CONDITION-1:0]        cond;
  logic [DATAWIDTH_JUMPADDRESS-1:0]      jump_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0]      incr_addr;
  logic [10:0]                           decode_full;
  logic [DATAWIDTH_JUMPADDRESS-1:0]      decode_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0]      next_addr;
  logic                                  mem_op;
  logic                                  unused_ir;

  assign cond        = mir_q[COND_LSB +: DATAWIDTH_CONDITION];
  assign jump_addr   = mir_q[DATAWIDTH_JUMPADDRESS-1:0];
  assign incr_addr   = csar_q + DATAWIDTH_JUMPADDRESS'(1);
  assign mem_op      = mir_q[RD_BIT] | mir_q[WR_BIT];
  // DECODE builds {1, op, op3, 00}; only meaningful for an 11-bit control store
  assign decode_full = {1'b1, ir[31:30], ir[24:19], 2'b00};
  assign decode_addr = DATAWIDTH_JUMPADDRESS'(decode_full);
  assign unused_ir   = ^ir;

  always_comb begin
    next_addr = incr_addr;
    case (cond)
      3'd1:    next_addr = flags[3] ? jump_addr : incr_addr;
      3'd2:    next_addr = flags[2] ? jump_addr : incr_addr;
      3'd3:    next_addr = flags[1] ? jump_addr : incr_addr;
      3'd4:    next_addr = flags[0] ? jump_addr : incr_addr;
      3'd5:    next_addr = ir[13]   ? jump_addr : incr_addr;
      3'd6:    next_addr = jump_addr;
      3'd7:    next_addr = decode_addr;
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    csar_d   = csar_q;
    mir_en   = 1'b0;
    mir_addr = csar_q;
    if (MICROCODE_SEQUENCER_Load_In) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ST_FETCH;
          csar_d  = '0;
        end
        ST_FETCH: begin
          state_d  = ST_RUN;
          mir_en   = 1'b1;
          mir_addr = csar_q;
        end
        ST_RUN: begin
          if (mem_op && !mem_ready) begin
            state_d = ST_WAIT;
          end else begin
            csar_d   = next_addr;
            mir_en   = 1'b1;
            mir_addr = next_addr;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state_d  = ST_RUN;
            csar_d   = next_addr;
            mir_en   = 1'b1;
            mir_addr = next_addr;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
    stall_d   = (state_d == ST_WAIT);
    loading_d = (state_d == ST_LOAD);
    active_d  = (state_d == ST_RUN) || (state_d == ST_WAIT);
  end

  assign cs_we = rst_n && (state_q == ST_LOAD) && MICROCODE_SEQUENCER_LoadWrite_In;

  always_ff @(posedge clk) begin
    if (cs_we) begin
      cs_mem[MICROCODE_SEQUENCER_LoadAddress_InBus] <= MICROCODE_SEQUENCER_LoadData_InBus;
    end
  end

  // MIR is the registered read port of the control store, so it tracks next_addr directly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      csar_q    <= '0;
      mir_q     <= '0;
      stall_q   <= 1'b0;
      loading_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      csar_q    <= csar_d;
      stall_q   <= stall_d;
      loading_q <= loading_d;
      active_q  <= active_d;
      if (mir_en) begin
        mir_q <= cs_mem[mir_addr];
      end
    end
  end

  assign MICROCODE_SEQUENCER_MIR_OutBus       = mir_q;
  assign MICROCODE_SEQUENCER_CSAddress_OutBus = csar_q;
  assign MICROCODE_SEQUENCER_RD_Out           = mir_q[RD_BIT] & active_q;
  assign MICROCODE_SEQUENCER_WRMain_Out       = mir_q[WR_BIT] & active_q;
  assign MICROCODE_SEQUENCER_Stall_Out        = stall_q;
  assign MICROCODE_SEQUENCER_Loading_Out      = loading_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: loads small microprograms and checks
// sequencing, branching, DECODE, memory stalls, wrap and reset/load interaction.
module tb_microcode_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  flags;
  logic [31:0] ir;
  logic        mem_ready;
  logic        load_in;
  logic [10:0] load_addr;
  logic [40:0] load_data;
  logic        load_write;
  logic [40:0] mir;
  logic [10:0] csar;
  logic        rd_out;
  logic        wr_out;
  logic        stall;
  logic        loading;

  int tests_run;
  int tests_failed;

  microcode_sequencer dut (
    .MICROCODE_SEQUENCER_CLOCK_50          (clk),
    .MICROCODE_SEQUENCER_ResetInLow_In     (rst_n),
    .MICROCODE_SEQUENCER_Flags_InBus       (flags),
    .MICROCODE_SEQUENCER_IR_InBus          (ir),
    .MICROCODE_SEQUENCER_MemReady_In       (mem_ready),
    .MICROCODE_SEQUENCER_Load_In           (load_in),
    .MICROCODE_SEQUENCER_LoadAddress_InBus (load_addr),
    .MICROCODE_SEQUENCER_LoadData_InBus    (load_data),
    .MICROCODE_SEQUENCER_LoadWrite_In      (load_write),
    .MICROCODE_SEQUENCER_MIR_OutBus        (mir),
    .MICROCODE_SEQUENCER_CSAddress_OutBus  (csar),
    .MICROCODE_SEQUENCER_RD_Out            (rd_out),
    .MICROCODE_SEQUENCER_WRMain_Out        (wr_out),
    .MICROCODE_SEQUENCER_Stall_Out         (stall),
    .MICROCODE_SEQUENCER_Loading_Out       (loading)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [40:0] mw(input logic [2:0] cond, input logic [10:0] jump,
                                     input logic rd, input logic wr, input logic [20:0] tag);
    logic [40:0] w;
    w        = '0;
    w[10:0]  = jump;
    w[13:11] = cond;
    w[18]    = wr;
    w[19]    = rd;
    w[40:20] = tag;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_load();
    load_in    = 1'b1;
    load_write = 1'b0;
    tick();
  endtask

  task automatic write_cs(input logic [10:0] a, input logic [40:0] d);
    load_addr  = a;
    load_data  = d;
    load_write = 1'b1;
    tick();
    load_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tests_run++; if (csar !== 11'd0) begin tests_failed++; $display("FAIL reset_csar got %0d exp 0", csar); end
    tests_run++; if (mir !== 41'd0) begin tests_failed++; $display("FAIL reset_mir got %h exp 0", mir); end
    tests_run++; if (stall !== 1'b0 || loading !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got stall=%b loading=%b exp 0 0", stall, loading); end
    tests_run++; if (rd_out !== 1'b0 || wr_out !== 1'b0) begin tests_failed++; $display("FAIL reset_rdwr got rd=%b wr=%b exp 0 0", rd_out, wr_out); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_reset_load();
    load_in = 1'b1;
    tick();
    tests_run++; if (loading !== 1'b0) begin tests_failed++; $display("FAIL rstprio_loading got %b exp 0", loading); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (loading !== 1'b1) begin tests_failed++; $display("FAIL rstrel_loading got %b exp 1", loading); end
    $display("[TB] test_reset_load done");
  endtask

  task automatic test_loop();
    logic [40:0] w0, w1;
    w0 = mw(3'd0, 11'd0, 1'b0, 1'b0, 21'h0A5A5);
    w1 = mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h15A5A);
    enter_load();
    write_cs(11'd0, w0);
    write_cs(11'd1, w1);
    load_in = 1'b0;
    tick();
    tests_run++; if (loading !== 1'b0 || csar !== 11'd0) begin tests_failed++; $display("FAIL loop_fetch got loading=%b csar=%0d exp 0 0", loading, csar); end
    tick();
    tests_run++; if (mir !== w0 || csar !== 11'd0) begin tests_failed++; $display("FAIL loop_first got mir=%h csar=%0d exp %h 0", mir, csar, w0); end
    load_addr = 11'd1; load_data = '1; load_write = 1'b1;
    tick();
    load_write = 1'b0;
    tests_run++; if (mir !== w1 || csar !== 11'd1) begin tests_failed++; $display("FAIL loop_1 got mir=%h csar=%0d exp %h 1", mir, csar, w1); end
    tick();
    tests_run++; if (mir !== w0 || csar !== 11'd0) begin tests_failed++; $display("FAIL loop_back got mir=%h csar=%0d exp %h 0", mir, csar, w0); end
    tick();
    tests_run++; if (mir !== w1 || csar !== 11'd1) begin tests_failed++; $display("FAIL loop_nowrite got mir=%h csar=%0d exp %h 1", mir, csar, w1); end
    tests_run++; if (rd_out !== 1'b0 || wr_out !== 1'b0) begin tests_failed++; $display("FAIL loop_rdwr got rd=%b wr=%b exp 0 0", rd_out, wr_out); end
    $display("[TB] test_loop done");
  endtask

  task automatic test_decode();
    logic [40:0] w0, w1, wd;
    w0 = mw(3'd0, 11'd0, 1'b0, 1'b0, 21'h00001);
    w1 = mw(3'd7, 11'd0, 1'b0, 1'b0, 21'h00002);
    wd = mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h00003);
    ir = 32'h8080_0000;
    enter_load();
    write_cs(11'd0, w0);
    write_cs(11'd1, w1);
    write_cs(11'd1600, wd);
    load_in = 1'b0;
    tick();
    tick();
    tick();
    tests_run++; if (mir !== w1 || csar !== 11'd1) begin tests_failed++; $display("FAIL decode_pre got mir=%h csar=%0d exp %h 1", mir, csar, w1); end
    tick();
    tests_run++; if (csar !== 11'd1600) begin tests_failed++; $display("FAIL decode_addr got %0d exp 1600", csar); end
    tests_run++; if (mir !== wd) begin tests_failed++; $display("FAIL decode_mir got %h exp %h", mir, wd); end
    $display("[TB] test_decode done");
  endtask

  task automatic test_ir13();
    logic [40:0] w1601, w1602;
    w1601 = mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h00016);
    w1602 = mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h00017);
    ir = 32'h0000_2000;
    enter_load();
    write_cs(11'd0, mw(3'd6, 11'd1600, 1'b0, 1'b0, 21'h00014));
    write_cs(11'd1600, mw(3'd5, 11'd1602, 1'b0, 1'b0, 21'h00015));
    write_cs(11'd1601, w1601);
    write_cs(11'd1602, w1602);
    load_in = 1'b0;
    tick();
    tick();
    tick();
    tests_run++; if (csar !== 11'd1600) begin tests_failed++; $display("FAIL ir13_jmp got %0d exp 1600", csar); end
    tick();
    tests_run++; if (csar !== 11'd1602 || mir !== w1602) begin tests_failed++; $display("FAIL ir13_taken got csar=%0d mir=%h exp 1602 %h", csar, mir, w1602); end
    tick();
    tick();
    ir = 32'h0000_0000;
    tick();
    tests_run++; if (csar !== 11'd1601 || mir !== w1601) begin tests_failed++; $display("FAIL ir13_not got csar=%0d mir=%h exp 1601 %h", csar, mir, w1601); end
    $display("[TB] test_ir13 done");
  endtask

  task automatic test_flags();
    flags = 4'b0001;
    enter_load();
    write_cs(11'd0, mw(3'd2, 11'd5, 1'b0, 1'b0, 21'h00020));
    write_cs(11'd1, mw(3'd4, 11'd6, 1'b0, 1'b0, 21'h00021));
    write_cs(11'd2, mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h00022));
    write_cs(11'd5, mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h00025));
    write_cs(11'd6, mw(3'd6, 11'd0, 1'b0, 1'b0, 21'h00026));
    load_in = 1'b0;
    tick();
    tick();
    tick();
    tests_run++; if (csar !== 11'd1) begin tests_failed++; $display("FAIL flag_z_not got %0d exp 1", csar); end
    tick();
    tests_run++; if (csar !== 11'd6) begin tests_failed++; $display("FAIL flag_c_taken got %0d exp 6", csar); end
    tick();
    flags = 4'b0100;
    tick();
    tests_run++; if (csar !== 11'd5) begin tests_failed++; $display("FAIL flag_z_taken got %0d exp 5", csar); end
    flags = 4'b0000;
    tick();
    tick();
    tick();
    tests_run++; if (csar !== 11'd2) begin tests_failed++; $display("FAIL flag_c_not got %0d exp 2", csar); end
    $display("[TB] test_flags done");
  endtask

  task automatic test_wait();
    mem_ready = 1'b0;
    enter_load();
    write_cs(11'd0, mw(3'd0, 11'd0, 1'b1, 1'b0, 21'h00030));
    write_cs(11'd1, mw(3'd6, 11'd0, 1'b0, 1'b1, 21'h00031));
    load_in = 1'b0;
    tick();
    tests_run++; if (rd_out !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL wait_fetch got rd=%b stall=%b exp 0 0", rd_out, stall); end
    tick();
    tests_run++; if (rd_out !== 1'b1 || stall !== 1'b0 || csar !== 11'd0) begin tests_failed++; $display("FAIL wait_run got rd=%b stall=%b csar=%0d exp 1 0 0", rd_out, stall, csar); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (stall !== 1'b1 || csar !== 11'd0 || rd_out !== 1'b1) begin tests_failed++; $display("FAIL wait_hold%0d got stall=%b csar=%0d rd=%b exp 1 0 1", i, stall, csar, rd_out); end
    end
    mem_ready = 1'b1;
    tick();
    tests_run++; if (csar !== 11'd1 || stall !== 1'b0 || wr_out !== 1'b1 || rd_out !== 1'b0) begin tests_failed++; $display("FAIL wait_release got csar=%0d stall=%b wr=%b rd=%b exp 1 0 1 0", csar, stall, wr_out, rd_out); end
    tick();
    tests_run++; if (csar !== 11'd0 || stall !== 1'b0 || rd_out !== 1'b1) begin tests_failed++; $display("FAIL wait_ready0 got csar=%0d stall=%b rd=%b exp 0 0 1", csar, stall, rd_out); end
    tick();
    tests_run++; if (csar !== 11'd1 || stall !== 1'b0) begin tests_failed++; $display("FAIL wait_ready1 got csar=%0d stall=%b exp 1 0", csar, stall); end
    $display("[TB] test_wait done");
  endtask

  task automatic test_reset_in_wait();
    mem_ready = 1'b0;
    tick();
    tests_run++; if (stall !== 1'b1 || csar !== 11'd1) begin tests_failed++; $display("FAIL rstwait_enter got stall=%b csar=%0d exp 1 1", stall, csar); end
    rst_n = 1'b0;
    tick();
    tests_run++; if (csar !== 11'd0 || mir !== 41'd0 || stall !== 1'b0 || wr_out !== 1'b0) begin tests_failed++; $display("FAIL rstwait_state got csar=%0d mir=%h stall=%b wr=%b exp 0 0 0 0", csar, mir, stall, wr_out); end
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    tests_run++; if (mir !== mw(3'd0, 11'd0, 1'b1, 1'b0, 21'h00030) || csar !== 11'd0) begin tests_failed++; $display("FAIL rstwait_retain got mir=%h csar=%0d exp %h 0", mir, csar, mw(3'd0, 11'd0, 1'b1, 1'b0, 21'h00030)); end
    $display("[TB] test_reset_in_wait done");
  endtask

  task automatic test_wrap();
    logic [40:0] w0, wl;
    w0 = mw(3'd6, 11'd2047, 1'b0, 1'b0, 21'h00040);
    wl = mw(3'd0, 11'd0, 1'b0, 1'b0, 21'h00041);
    enter_load();
    write_cs(11'd0, w0);
    write_cs(11'd2047, wl);
    load_in = 1'b0;
    tick();
    tick();
    tick();
    tests_run++; if (csar !== 11'd2047 || mir !== wl) begin tests_failed++; $display("FAIL wrap_top got csar=%0d mir=%h exp 2047 %h", csar, mir, wl); end
    tick();
    tests_run++; if (csar !== 11'd0 || mir !== w0) begin tests_failed++; $display("FAIL wrap_zero got csar=%0d mir=%h exp 0 %h", csar, mir, w0); end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_load_abort();
    load_in = 1'b1;
    tick();
    tests_run++; if (loading !== 1'b1 || stall !== 1'b0 || rd_out !== 1'b0 || wr_out !== 1'b0) begin tests_failed++; $display("FAIL abort got loading=%b stall=%b rd=%b wr=%b exp 1 0 0 0", loading, stall, rd_out, wr_out); end
    load_in = 1'b0;
    tick();
    tests_run++; if (loading !== 1'b0 || csar !== 11'd0) begin tests_failed++; $display("FAIL abort_exit got loading=%b csar=%0d exp 0 0", loading, csar); end
    $display("[TB] test_load_abort done");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    flags        = 4'b0000;
    ir           = 32'h0;
    mem_ready    = 1'b1;
    load_in      = 1'b0;
    load_addr    = 11'd0;
    load_data    = 41'd0;
    load_write   = 1'b0;
    tick();
    test_reset();
    test_reset_load();
    test_loop();
    test_decode();
    test_ir13();
    test_flags();
    test_wait();
    test_reset_in_wait();
    test_wrap();
    test_load_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised, writable ARC-style control unit: holds the microprogram in an internal synchronous-read RAM, sequences it through a CS address register (CSAR), and presents the current microword in a registered MIR.
- Implements next-address logic (increment, conditional jump, unconditional jump, DECODE), memory-wait stalls, and a load port for writing microcode at run time.
- Feeds the datapath A/B/C selects, ALU operation and main-memory RD/WR controls; takes back the PSR flags and the IR.

Parameters:
- DATAWIDTH_JUMPADDRESS, 11, CSAR/jump-field width; control-store depth = 2^DATAWIDTH_JUMPADDRESS. DECODE mode requires 11.
- DATAWIDTH_MICROINSTRUCTION, 41, microword width.
- DATAWIDTH_CONDITION, 3, COND field width; fixed at 3.
- COND_LSB, 11, LSB of COND field; JUMP field is [DATAWIDTH_JUMPADDRESS-1:0].
- WR_BIT, 18, main-memory write bit position in the microword.
- RD_BIT, 19, main-memory read bit position in the microword.
- DATAWIDTH_IR, 32, instruction register width.

Ports:
- MICROCODE_SEQUENCER_CLOCK_50  in  1  system clock.
- MICROCODE_SEQUENCER_ResetInLow_In  in  1  synchronous active-low reset.
- MICROCODE_SEQUENCER_Flags_InBus  in  4  {N,Z,V,C} from PSR.
- MICROCODE_SEQUENCER_IR_InBus  in  DATAWIDTH_IR  instruction register.
- MICROCODE_SEQUENCER_MemReady_In  in  1  main memory has completed the current RD/WR.
- MICROCODE_SEQUENCER_Load_In  in  1  load mode request.
- MICROCODE_SEQUENCER_LoadAddress_InBus  in  DATAWIDTH_JUMPADDRESS  control-store write address.
- MICROCODE_SEQUENCER_LoadData_InBus  in  DATAWIDTH_MICROINSTRUCTION  microword to write.
- MICROCODE_SEQUENCER_LoadWrite_In  in  1  write strobe, honoured only in LOAD.
- MICROCODE_SEQUENCER_MIR_OutBus  out  DATAWIDTH_MICROINSTRUCTION  current microword (registered).
- MICROCODE_SEQUENCER_CSAddress_OutBus  out  DATAWIDTH_JUMPADDRESS  CSAR (address of current MIR).
- MICROCODE_SEQUENCER_RD_Out  out  1  MIR[RD_BIT], gated to 0 outside RUN/WAIT.
- MICROCODE_SEQUENCER_WRMain_Out  out  1  MIR[WR_BIT], gated to 0 outside RUN/WAIT.
- MICROCODE_SEQUENCER_Stall_Out  out  1  high in WAIT.
- MICROCODE_SEQUENCER_Loading_Out  out  1  high in LOAD.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values: state=FETCH, CSAR=0, MIR=0 (COND=0, RD=WR=0), Stall=0, Loading=0. Control-store contents are not reset.
- States:
  - LOAD: Loading=1. Writes CS[LoadAddress]<=LoadData when LoadWrite=1. Exits to FETCH with CSAR=0 when Load_In falls.
  - FETCH: one-cycle RAM read of CS[CSAR]. Next cycle MIR<=CS[CSAR], state RUN.
  - RUN: computes next address from the MIR (below).
    - If (RD|WR)=1 and MemReady=0: go to WAIT; MIR and CSAR held.
    - Otherwise: CSAR<=next and MIR<=CS[next] on the same edge (RAM addressed with next combinationally). One microinstruction per cycle.
  - WAIT: Stall=1, holds MIR/CSAR. On MemReady=1, advances exactly as RUN would, state RUN.
- Load_In=1 in any state: go to LOAD next cycle; an in-flight microinstruction is abandoned. Reset has priority over Load.
- Next address, by COND:
  - 0: CSAR+1.
  - 1: N ? JUMP : CSAR+1.
  - 2: Z ? JUMP : CSAR+1.
  - 3: V ? JUMP : CSAR+1.
  - 4: C ? JUMP : CSAR+1.
  - 5: IR[13] ? JUMP : CSAR+1.
  - 6: JUMP.
  - 7: DECODE = {1'b1, IR[31:30], IR[24:19], 2'b00}.
- Arithmetic and sampling rules:
  - CSAR+1 wraps from 2^DATAWIDTH_JUMPADDRESS-1 to 0.
  - Flags and IR are sampled combinationally in the cycle the branching MIR is present; in WAIT they are sampled on the releasing cycle.
- Simultaneous events:
  - LoadWrite to the address being fetched in the FETCH exit cycle cannot occur, because LOAD is exclusive.
  - Reset deasserting while Load=1 gives FETCH for one cycle, then LOAD.
- Latency: Load_In fall to first valid MIR = 2 cycles (LOAD→FETCH→RUN).

Test Plan:
- Load CS[0]=41'h0_0000_0000_0 (COND=0), CS[1]=COND 6/JUMP 0; release -> CSAddress cycles 0,1,0,1…, MIR matches the loaded words, RD/WR=0.
- CS[1] COND=7, IR op=2'b10, op3=6'b010000 (ADDCC) -> next CSAddress=11'b11001000000 (1600) one cycle after MIR(1).
- CS[1600] COND=5, JUMP=1602; IR[13]=1 -> CSAR=1602; IR[13]=0 -> CSAR=1601.
- CS[0] RD=1, COND=0; MemReady low 3 cycles -> Stall=1 for 3 cycles, CSAR stays 0, RD_Out stays 1; MemReady=1 -> CSAR=1 next edge.
- Jump to 2047 with COND=0 there -> next CSAR=0 (wrap).
- Assert ResetInLow=0 during WAIT -> next edge CSAR=0, MIR=0, Stall=0, state FETCH; CS contents retained (MIR=CS[0] one cycle after release).
